// File: rtl/cam_pkg.sv
`default_nettype none
// cam_pkg -- shared state encoding, pixel type and crop/decimation test for cam_window_ctrl (rev 1.0)
package cam_pkg;

    localparam int COL_W = 12;
    localparam int ROW_W = 12;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_VS     = 3'd1,
        FRAME_START = 3'd2,
        ACTIVE      = 3'd3,
        DONE        = 3'd4
    } cam_win_state_t;

    typedef logic [15:0] pix565_t;

    // Position lies in [lo,hi) and its offset from lo is a multiple of 2^shift.
    function automatic logic in_window(input logic [COL_W-1:0] pos,
                                       input logic [COL_W-1:0] lo,
                                       input logic [COL_W-1:0] hi,
                                       input int unsigned      shift);
        logic [COL_W-1:0] off;
        logic [COL_W-1:0] mask;
        off  = pos - lo;
        mask = (COL_W'(1) << shift) - COL_W'(1);
        return (pos >= lo) && (pos < hi) && ((off & mask) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cam_window_ctrl_if.sv
`default_nettype none
// cam_window_ctrl_if -- camera pins, arm controls and FIFO write port of the window sequencer (rev 1.0)
interface cam_window_ctrl_if;
    import cam_pkg::*;

    logic       start_en;
    logic       cont_read;
    logic       vsync;
    logic       href;
    logic [7:0] p_data;
    logic       fifo_full;
    logic       wr_en;
    pix565_t    wr_data;
    logic       busy;
    logic       frame_done;
    logic       overflow;
    logic [15:0] pix_cnt;

    modport master (
        output start_en, cont_read, vsync, href, p_data, fifo_full,
        input  wr_en, wr_data, busy, frame_done, overflow, pix_cnt
    );

    modport slave (
        input  start_en, cont_read, vsync, href, p_data, fifo_full,
        output wr_en, wr_data, busy, frame_done, overflow, pix_cnt
    );

endinterface
`default_nettype wire

// File: rtl/cam_byte_pair.sv
`default_nettype none
// cam_byte_pair -- byte phase tracking and {first,second} RGB565 assembly (rev 1.0)
module cam_byte_pair
    import cam_pkg::*;
(
    input  wire logic       p_clock,
    input  wire logic       resetn,
    input  wire logic       byte_vld,
    input  wire logic       clr,
    input  wire logic [7:0] p_data,
    output logic            pix_vld,
    output pix565_t         pixel
);

    logic       phase_q, phase_d;
    logic [7:0] hi_q, hi_d;

    always_comb begin
        phase_d = phase_q;
        hi_d    = hi_q;
        if (clr) begin
            phase_d = 1'b0;
        end else if (byte_vld) begin
            phase_d = ~phase_q;
            if (!phase_q) hi_d = p_data;
        end
    end

    always_ff @(posedge p_clock or negedge resetn) begin
        if (!resetn) begin
            phase_q <= 1'b0;
            hi_q    <= 8'd0;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
        end
    end

    assign pix_vld = byte_vld & phase_q & ~clr;
    assign pixel   = {hi_q, p_data};

endmodule
`default_nettype wire

// File: rtl/cam_window_ctrl.sv
`default_nettype none
// cam_window_ctrl -- arm/frame sequencer, ROI crop and 2^DEC_SHIFT decimation into the pixel FIFO (rev 1.0)
// Optional build macro CAM_WIN_TEST_PATTERN_EN replaces pixel data with {row,col} of each kept pixel.
module cam_window_ctrl
    import cam_pkg::*;
#(
    parameter int unsigned IMG_W     = 640,
    parameter int unsigned IMG_H     = 480,
    parameter int unsigned CROP_X0   = 80,
    parameter int unsigned CROP_Y0   = 0,
    parameter int unsigned CROP_W    = 480,
    parameter int unsigned CROP_H    = 480,
    parameter int unsigned DEC_SHIFT = 4
)(
    input wire logic         p_clock,
    input wire logic         resetn,
    cam_window_ctrl_if.slave bus
);

    localparam logic [COL_W-1:0] X_LO  = COL_W'(CROP_X0);
    localparam logic [COL_W-1:0] X_HI  = COL_W'(CROP_X0 + CROP_W);
    localparam logic [ROW_W-1:0] Y_LO  = ROW_W'(CROP_Y0);
    localparam logic [ROW_W-1:0] Y_HI  = ROW_W'(CROP_Y0 + CROP_H);
    localparam logic [COL_W-1:0] COL_M = COL_W'(IMG_W);
    localparam logic [ROW_W-1:0] ROW_M = ROW_W'(IMG_H);

    cam_win_state_t   state_q, state_d;
    logic             start_meta_q, start_meta_d, start_s_q, start_s_d;
    logic             href_prev_q, href_prev_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             wr_en_q, wr_en_d;
    pix565_t          wr_data_q, wr_data_d;
    logic             frame_done_q, frame_done_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      pix_cnt_q, pix_cnt_d;

    logic    busy, arm, active, frame_end, restart;
    logic    href_fall, byte_vld, line_clr, pix_vld, keep;
    pix565_t pixel, new_word;

    // State register
    always_ff @(posedge p_clock or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (start_s_q) state_d = WAIT_VS;
            WAIT_VS:     if (!start_s_q) state_d = IDLE;
                         else if (bus.vsync) state_d = FRAME_START;
            FRAME_START: if (!start_s_q) state_d = IDLE;
                         else if (!bus.vsync) state_d = ACTIVE;
            ACTIVE:      if (bus.vsync) state_d = (bus.cont_read && start_s_q) ? FRAME_START : DONE;
            DONE:        if (!start_s_q) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = (state_q != IDLE);
        arm       = (state_q == IDLE) && start_s_q;
        active    = (state_q == ACTIVE);
        frame_end = active && bus.vsync;
        restart   = frame_end && bus.cont_read && start_s_q;
    end

    assign href_fall = href_prev_q & ~bus.href;
    assign byte_vld  = active & bus.href & ~bus.vsync;
    assign line_clr  = ~active | bus.vsync | href_fall;

    cam_byte_pair u_byte_pair (
        .p_clock  (p_clock),
        .resetn   (resetn),
        .byte_vld (byte_vld),
        .clr      (line_clr),
        .p_data   (bus.p_data),
        .pix_vld  (pix_vld),
        .pixel    (pixel)
    );

    assign keep = pix_vld && in_window(col_q, X_LO, X_HI, DEC_SHIFT)
                          && in_window(row_q, Y_LO, Y_HI, DEC_SHIFT);

`ifdef CAM_WIN_TEST_PATTERN_EN
    assign new_word = {row_q[7:0], col_q[7:0]};
`else
    assign new_word = pixel;
`endif

    always_comb begin
        start_meta_d = bus.start_en;
        start_s_d    = start_meta_q;
        href_prev_d  = bus.href;
        col_d        = col_q;
        row_d        = row_q;
        if (!active) begin
            col_d = '0;
            row_d = '0;
        end else if (href_fall) begin
            col_d = '0;
            if (row_q != ROW_M) row_d = row_q + ROW_W'(1);
        end else if (pix_vld && (col_q != COL_M)) begin
            col_d = col_q + COL_W'(1);
        end
        wr_en_d      = keep & ~bus.fifo_full;
        wr_data_d    = wr_en_d ? new_word : wr_data_q;
        frame_done_d = frame_end;
        overflow_d   = arm ? 1'b0 : (overflow_q | (keep & bus.fifo_full));
        pix_cnt_d    = (arm || restart) ? 16'd0 : (pix_cnt_q + {15'd0, wr_en_d});
    end

    always_ff @(posedge p_clock or negedge resetn) begin
        if (!resetn) begin
            start_meta_q <= 1'b0;
            start_s_q    <= 1'b0;
            href_prev_q  <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            pix_cnt_q    <= 16'd0;
        end else begin
            start_meta_q <= start_meta_d;
            start_s_q    <= start_s_d;
            href_prev_q  <= href_prev_d;
            col_q        <= col_d;
            row_q        <= row_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            pix_cnt_q    <= pix_cnt_d;
        end
    end

    assign bus.busy       = busy;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overflow   = overflow_q;
    assign bus.pix_cnt    = pix_cnt_q;

endmodule
`default_nettype wire
